rr_mux4_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares a 4:1 data mux between four requesters (a, b, c, d) and one downstream consumer.
- Each requester offers a valid/ready stream; the block picks a winner, drives the mux selects, and registers the selected word onto a single valid/ready output.
- A winner may hold the mux for up to BURST_MAX back-to-back beats before the grant must rotate.

---
 rtl/rr_mux4_arbiter.sv | 230 +++++++++++++++++++++++
 tb/tb_rr_mux4_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/rr_mux4_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_mux4_arbiter
//  Purpose  : Round-robin arbiter/sequencer sharing one 4:1 data mux between
//             four valid/ready requesters (a, b, c, d) and a single registered
//             valid/ready output. A winner may keep the mux for up to
//             BURST_MAX back-to-back beats before the grant rotates.
//
//  Parameters
//     DATA_W     width of each requester word and of y
//     BURST_MAX  max consecutive beats per grant (>= 1)
//
//  Ports
//     clk        clock, rising-edge active
//     rst_n      asynchronous active-low reset
//     req[3:0]   per-requester valid (0=a, 1=b, 2=c, 3=d)
//     ack[3:0]   per-requester ready (combinational)
//     a,b,c,d    requester data, sampled on the transfer edge
//     y          registered selected data
//     y_valid    y holds an unconsumed beat
//     y_ready    consumer accepts y when y_valid && y_ready
//     grant[3:0] registered one-hot current owner, 0 when idle
//     s0, s1     registered mux select, index = {s0,s1}
//
//  Revision : 1.0  initial release
// ============================================================================
module rr_mux4_arbiter #(
   parameter int DATA_W    = 8,
   parameter int BURST_MAX = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [3:0]        req,
   output logic [3:0]        ack,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [DATA_W-1:0] c,
   input  logic [DATA_W-1:0] d,
   output logic [DATA_W-1:0] y,
   output logic              y_valid,
   input  logic              y_ready,
   output logic [3:0]        grant,
   output logic              s0,
   output logic              s1
);

   // ------------------------------------------------------------------------
   // Constants and state encoding
   // ------------------------------------------------------------------------
   localparam int                 C_CNT_W     = $clog2(BURST_MAX + 1);
   localparam logic [C_CNT_W-1:0] C_CNT_ONE   = C_CNT_W'(1);
   localparam logic [C_CNT_W-1:0] C_BURST_LIM = C_CNT_W'(BURST_MAX);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   // ------------------------------------------------------------------------
   // Registered state
   // ------------------------------------------------------------------------
   state_t              state_q,   state_d;
   logic [1:0]          ptr_q,     ptr_d;      // highest-priority index
   logic [C_CNT_W-1:0]  cnt_q,     cnt_d;      // beats taken in this grant
   logic [DATA_W-1:0]   y_q,       y_d;
   logic                y_valid_q, y_valid_d;
   logic [3:0]          grant_q,   grant_d;
   logic [1:0]          sel_q,     sel_d;      // current owner / mux select

   // ------------------------------------------------------------------------
   // Combinational decision signals
   // ------------------------------------------------------------------------
   logic [1:0]          w_scan_ptr;   // where the round-robin scan starts
   logic [2:0]          w_pick;       // {found, index} from the scan
   logic                w_cap_en;     // load a new beat into y this cycle
   logic [1:0]          w_cap_idx;    // requester supplying that beat
   logic [DATA_W-1:0]   w_mux;        // 4:1 data mux output

   // Round-robin scan: first requester at or after p (mod 4).
   // Iterating from the far end down lets the nearest hit overwrite the rest.
   function automatic logic [2:0] rr_pick(input logic [3:0] r,
                                          input logic [1:0] p);
      logic [2:0] res;
      logic [1:0] idx;
      res = 3'b000;
      for (int k = 3; k >= 0; k--) begin
         idx = p + 2'(k);
         if (r[idx]) begin
            res = {1'b1, idx};
         end
      end
      return res;
   endfunction

   // In IDLE the scan starts at ptr. In BUSY a rotation starts just past the
   // current owner, so a sole requester with an exhausted burst wraps back
   // onto itself and keeps streaming without a bubble.
   always_comb begin
      w_scan_ptr = ptr_q;
      if (state_q == ST_BUSY) begin
         w_scan_ptr = sel_q + 2'd1;
      end
   end

   assign w_pick = rr_pick(req, w_scan_ptr);

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      y_valid_d = y_valid_q;
      grant_d   = grant_q;
      w_cap_en  = 1'b0;
      w_cap_idx = sel_q;

      case (state_q)
         ST_IDLE: begin
            if (w_pick[2]) begin
               w_cap_en  = 1'b1;
               w_cap_idx = w_pick[1:0];
               cnt_d     = C_CNT_ONE;
               state_d   = ST_BUSY;
            end
         end

         ST_BUSY: begin
            // Nothing moves until the consumer takes the beat in y.
            if (y_ready) begin
               if (req[sel_q] && (cnt_q < C_BURST_LIM)) begin
                  // Same owner continues its burst.
                  w_cap_en  = 1'b1;
                  w_cap_idx = sel_q;
                  cnt_d     = cnt_q + C_CNT_ONE;
               end else begin
                  // Burst exhausted or owner dropped req: rotate.
                  ptr_d = sel_q + 2'd1;
                  if (w_pick[2]) begin
                     w_cap_en  = 1'b1;
                     w_cap_idx = w_pick[1:0];
                     cnt_d     = C_CNT_ONE;
                  end else begin
                     state_d   = ST_IDLE;
                     y_valid_d = 1'b0;
                     grant_d   = 4'b0000;
                     cnt_d     = '0;
                  end
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (w_cap_en) begin
         y_valid_d = 1'b1;
         grant_d   = 4'b0001 << w_cap_idx;
      end
   end

   // ------------------------------------------------------------------------
   // Shared 4:1 data mux, steered by the requester being captured
   // ------------------------------------------------------------------------
   always_comb begin
      case (w_cap_idx)
         2'd0:    w_mux = a;
         2'd1:    w_mux = b;
         2'd2:    w_mux = c;
         default: w_mux = d;
      endcase
   end

   // y and the select hold their last value unless a new beat is captured;
   // the select deliberately keeps pointing at the last owner when idle.
   always_comb begin
      y_d   = y_q;
      sel_d = sel_q;
      if (w_cap_en) begin
         y_d   = w_mux;
         sel_d = w_cap_idx;
      end
   end

   // Ready goes only to the requester being captured. Gated by rst_n so no
   // transfer is signalled while the block is held in reset.
   always_comb begin
      ack = 4'b0000;
      if (w_cap_en && rst_n) begin
         ack = 4'b0001 << w_cap_idx;
      end
   end

   // ------------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         ptr_q     <= 2'd0;
         cnt_q     <= '0;
         y_q       <= '0;
         y_valid_q <= 1'b0;
         grant_q   <= 4'b0000;
         sel_q     <= 2'd0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         cnt_q     <= cnt_d;
         y_q       <= y_d;
         y_valid_q <= y_valid_d;
         grant_q   <= grant_d;
         sel_q     <= sel_d;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign y       = y_q;
   assign y_valid = y_valid_q;
   assign grant   = grant_q;
   assign s0      = sel_q[1];
   assign s1      = sel_q[0];

endmodule
`default_nettype wire

// File: tb/tb_rr_mux4_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_rr_mux4_arbiter
//  Purpose  : Self-checking bench for rr_mux4_arbiter. Directed stimulus
//             pushes hand-computed expected beats into a queue; a monitor
//             pops and compares on every output handshake.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rr_mux4_arbiter;

   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [3:0]    req;
   logic [3:0]    ack;
   logic [DW-1:0] a, b, c, d, y;
   logic          y_valid, y_ready;
   logic [3:0]    grant;
   logic          s0, s1;

   always #5 clk = ~clk;

   rr_mux4_arbiter #(.DATA_W(DW), .BURST_MAX(4)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .ack     (ack),
      .a       (a),
      .b       (b),
      .c       (c),
      .d       (d),
      .y       (y),
      .y_valid (y_valid),
      .y_ready (y_ready),
      .grant   (grant),
      .s0      (s0),
      .s1      (s1)
   );

   typedef struct packed {
      logic [7:0] y;
      logic [3:0] g;
      logic [1:0] sel;
   } beat_t;

   beat_t exp_q[$];
   int    n_checks  = 0;
   int    n_pass    = 0;
   int    n_hs      = 0;
   int    n_ack     = 0;
   int    n_discard = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic apply_reset();
      req     = 4'b0000;
      y_ready = 1'b0;
      rst_n   = 1'b0;
      step();
      rst_n   = 1'b1;
   endtask

   // Monitor: sampled on the falling edge, mid-cycle, when inputs are stable.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         n_ack += $countones(req & ack);
         if (y_valid === 1'b1 && y_ready === 1'b1) begin
            n_hs++;
            if (exp_q.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_beat: got y=0x%0h grant=%b, expected no beat", y, grant);
            end else begin
               chk("beat", {y, grant, s0, s1}, exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      logic [3:0] gap;
      int         idx;

      // ---------------- reset / idle ----------------
      rst_n   = 1'b0;
      req     = 4'($urandom);
      y_ready = 1'($urandom);
      a = 8'h11; b = 8'h22; c = 8'h33; d = 8'h44;
      step();
      step();
      #1 chk("rst_outputs", {y, y_valid, grant, s0, s1}, 0);
      chk("rst_ack", ack, 4'b0000);
      req   = 4'b0000;
      rst_n = 1'b1;
      repeat (5) begin
         step();
         chk("idle_outputs", {y, y_valid, grant, s0, s1}, 0);
      end

      // ---------------- single beat from c ----------------
      req = 4'b0100; c = 8'hC3; y_ready = 1'b1;
      #1 chk("single_ack", ack, 4'b0100);
      exp_q.push_back({8'hC3, 4'b0100, 2'd2});
      step();
      req = 4'b0000;
      #1 chk("single_ack_drop", ack, 4'b0000);
      chk("single_out", {y, y_valid, grant, s0, s1}, {8'hC3, 1'b1, 4'b0100, 2'd2});
      step();
      #1 chk("single_idle", {y_valid, grant, s0, s1}, {1'b0, 4'b0000, 2'd2});

      // ptr is now 3: with a and d requesting, d must win
      req = 4'b1001; d = 8'hD4;
      #1 chk("ptr_wrap_ack", ack, 4'b1000);
      exp_q.push_back({8'hD4, 4'b1000, 2'd3});
      step();
      req = 4'b0000;
      step();
      #1 chk("ptr_wrap_idle", y_valid, 1'b0);

      // ---------------- full contention ----------------
      apply_reset();
      a = 8'h01; b = 8'h02; c = 8'h03; d = 8'h04;
      y_ready = 1'b1; req = 4'b1111;
      for (int i = 0; i < 20; i++) begin
         idx = (i / 4) % 4;
         exp_q.push_back({8'(idx + 1), 4'(4'b0001 << idx), 2'(idx)});
      end
      gap = 4'd0;
      repeat (20) begin
         step();
         if (y_valid !== 1'b1) gap = 4'd1;
      end
      req = 4'b0000;
      step();
      chk("contention_no_gap", gap, 0);
      #1 chk("contention_idle", y_valid, 1'b0);

      // ---------------- backpressure mid-burst ----------------
      apply_reset();
      a = 8'hA1; b = 8'hB2; req = 4'b0011; y_ready = 1'b1;
      repeat (4) exp_q.push_back({8'hA1, 4'b0001, 2'd0});
      repeat (2) exp_q.push_back({8'hB2, 4'b0010, 2'd1});
      step();
      step();
      y_ready = 1'b0;
      a = 8'hEE;   // must not leak into y while stalled
      for (int k = 0; k < 3; k++) begin
         #1 chk("bp_ack", ack, 4'b0000);
         chk("bp_frozen", {y, y_valid, grant, s0, s1}, {8'hA1, 1'b1, 4'b0001, 2'd0});
         step();
      end
      #1 chk("bp_frozen_end", {y, y_valid, grant, s0, s1}, {8'hA1, 1'b1, 4'b0001, 2'd0});
      a = 8'hA1; y_ready = 1'b1;
      repeat (4) step();
      req = 4'b0000;
      step();
      #1 chk("bp_idle", y_valid, 1'b0);

      // ---------------- sole requester across burst limit ----------------
      apply_reset();
      y_ready = 1'b1; req = 4'b0010;
      for (int k = 0; k < 6; k++) begin
         b = 8'(8'h51 + k);
         exp_q.push_back({b, 4'b0010, 2'd1});
         #1 chk("sole_ack", ack, 4'b0010);
         step();
         chk("sole_grant", {grant, y_valid}, {4'b0010, 1'b1});
      end
      req = 4'b0000;
      step();
      #1 chk("sole_idle", y_valid, 1'b0);

      // ---------------- async reset mid-burst ----------------
      apply_reset();
      y_ready = 1'b0; a = 8'h77; req = 4'b0001;
      n_discard++;   // this beat is thrown away by the reset
      step();
      #1 chk("pre_rst_valid", {y, y_valid, grant}, {8'h77, 1'b1, 4'b0001});
      rst_n = 1'b0;
      #0.5 chk("async_rst", {y, y_valid, grant, s0, s1}, 0);
      chk("async_rst_ack", ack, 4'b0000);
      req = 4'b1000; d = 8'h4D; y_ready = 1'b1;
      rst_n = 1'b1;
      exp_q.push_back({8'h4D, 4'b1000, 2'd3});
      #0.5 chk("post_rst_ack", ack, 4'b1000);
      step();
      req = 4'b0000;
      step();
      #1 chk("post_rst_idle", y_valid, 1'b0);

      // ---------------- drain and wrap up ----------------
      for (int t = 0; t < 50 && exp_q.size() != 0; t++) step();
      chk("queue_drained", exp_q.size(), 0);
      chk("ack_vs_beats", n_ack, n_hs + n_discard);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
